// File: rtl/des_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : des_block_sequencer
// Purpose  : Walks a 2048-byte input buffer, one 64-bit block at a time,
//            through an external 16-round DES round core. Each result goes to
//            a 2048-byte output buffer. A one-cycle done pulse is issued
//            after all 256 blocks have been written.
// Ports    : clk1, reset         - clock, synchronous active-high reset
//            start, decrypt, key - run control, mode and 64-bit key with parity
//            done                - one-cycle completion pulse
//            ram_i_addr/dout     - input buffer read port (1-cycle latency)
//            ram_o_addr/din/we   - output buffer write port
//            des_in/round_sel/key/decrypt/out - DES round core interface
//            led                 - inverted round select for board LEDs
// Revision : 1.0 - initial release
// ============================================================================
module des_block_sequencer (
    input  logic        clk1,
    input  logic        reset,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key,
    output logic        done,
    output logic [8:0]  ram_i_addr,
    input  logic [31:0] ram_i_dout,
    output logic [8:0]  ram_o_addr,
    output logic [31:0] ram_o_din,
    output logic        ram_o_we,
    output logic [63:0] des_in,
    output logic [3:0]  des_round_sel,
    output logic [55:0] des_key,
    output logic        des_decrypt,
    input  logic [63:0] des_out,
    output logic [7:0]  led
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LOAD1 = 4'd1,
        S_LOAD2 = 4'd2,
        S_LOAD3 = 4'd3,
        S_DODES = 4'd4,
        S_SAVE1 = 4'd5,
        S_SAVE2 = 4'd6,
        S_SAVE3 = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    state_t      state_q;
    logic        done_q;
    logic [8:0]  ram_i_addr_q;
    logic [8:0]  ram_o_addr_q;
    logic [31:0] ram_o_din_q;
    logic        ram_o_we_q;
    logic [63:0] des_in_q;
    logic [63:0] result_q;
    logic [3:0]  round_q;

    // Incremented values; the 9-bit address wrap after word 511 is what
    // signals the end of the buffer.
    logic [8:0]  ram_i_addr_d;
    logic [8:0]  ram_o_addr_d;
    logic [3:0]  round_d;

    assign ram_i_addr_d = ram_i_addr_q + 9'd1;
    assign ram_o_addr_d = ram_o_addr_q + 9'd1;
    assign round_d      = round_q + 4'd1;

    // Parity bits (bit 0 of each key byte) are dropped from the DES key.
    logic [7:0] unused_parity;
    assign unused_parity = {key[56], key[48], key[40], key[32],
                            key[24], key[16], key[8],  key[0]};

    assign des_key = {key[63:57], key[55:49], key[47:41], key[39:33],
                      key[31:25], key[23:17], key[15:9],  key[7:1]};

    assign des_decrypt   = decrypt;
    assign done          = done_q;
    assign ram_i_addr    = ram_i_addr_q;
    assign ram_o_addr    = ram_o_addr_q;
    assign ram_o_din     = ram_o_din_q;
    assign ram_o_we      = ram_o_we_q;
    assign des_in        = des_in_q;
    assign des_round_sel = round_q;
    assign led           = ~{4'b0000, round_q};

    always_ff @(posedge clk1) begin
        if (reset) begin
            state_q      <= S_IDLE;
            done_q       <= 1'b0;
            ram_i_addr_q <= 9'd0;
            ram_o_addr_q <= 9'd0;
            ram_o_din_q  <= 32'd0;
            ram_o_we_q   <= 1'b0;
            des_in_q     <= 64'd0;
            result_q     <= 64'd0;
            round_q      <= 4'd0;
        end else begin
            // Pulse-type outputs drop back to zero unless a state raises them.
            done_q     <= 1'b0;
            ram_o_we_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        ram_i_addr_q <= 9'd0;
                        ram_o_addr_q <= 9'd0;
                        state_q      <= S_LOAD1;
                    end
                end

                // Address for the low word is already on the RAM; step to
                // the high word while the low word is being read.
                S_LOAD1: begin
                    ram_i_addr_q <= ram_i_addr_d;
                    state_q      <= S_LOAD2;
                end

                S_LOAD2: begin
                    des_in_q[31:0] <= ram_i_dout;
                    ram_i_addr_q   <= ram_i_addr_d;
                    state_q        <= S_LOAD3;
                end

                S_LOAD3: begin
                    des_in_q[63:32] <= ram_i_dout;
                    round_q         <= 4'd0;
                    state_q         <= S_DODES;
                end

                // Sixteen rounds; the core output is valid while round 15 is
                // selected. The round counter wraps back to 0 on exit.
                S_DODES: begin
                    round_q <= round_d;
                    if (round_q == 4'd15) begin
                        result_q <= des_out;
                        state_q  <= S_SAVE1;
                    end
                end

                S_SAVE1: begin
                    ram_o_din_q <= result_q[31:0];
                    ram_o_we_q  <= 1'b1;
                    state_q     <= S_SAVE2;
                end

                S_SAVE2: begin
                    ram_o_din_q  <= result_q[63:32];
                    ram_o_we_q   <= 1'b1;
                    ram_o_addr_q <= ram_o_addr_d;
                    state_q      <= S_SAVE3;
                end

                // Input address wraps to 0 only after the last block was read.
                S_SAVE3: begin
                    ram_o_addr_q <= ram_o_addr_d;
                    if (ram_i_addr_q == 9'd0) begin
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_LOAD1;
                    end
                end

                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_des_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_block_sequencer
// Purpose  : Self-checking bench for des_block_sequencer. Behavioural input
//            and output RAMs plus a toy DES core surround the design; expected
//            results come from a block-level reference computed from the
//            input buffer contents and the key.
// Revision : 1.0 - initial release
// ============================================================================
module tb_des_block_sequencer;

    localparam int C_BLOCKS     = 256;
    localparam int C_BLOCK_CYC  = 22;
    localparam int C_DONE_CYC   = 1 + C_BLOCKS * C_BLOCK_CYC + 1;   // 5634

    logic        clk1 = 1'b0;
    logic        reset;
    logic        start;
    logic        decrypt;
    logic [63:0] key;
    logic        done;
    logic [8:0]  ram_i_addr;
    logic [31:0] ram_i_dout;
    logic [8:0]  ram_o_addr;
    logic [31:0] ram_o_din;
    logic        ram_o_we;
    logic [63:0] des_in;
    logic [3:0]  des_round_sel;
    logic [55:0] des_key;
    logic        des_decrypt;
    logic [63:0] des_out;
    logic [7:0]  led;

    logic [31:0] in_mem  [0:511];
    logic [31:0] out_mem [0:511];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk1 = ~clk1;

    des_block_sequencer dut (
        .clk1          (clk1),
        .reset         (reset),
        .start         (start),
        .decrypt       (decrypt),
        .key           (key),
        .done          (done),
        .ram_i_addr    (ram_i_addr),
        .ram_i_dout    (ram_i_dout),
        .ram_o_addr    (ram_o_addr),
        .ram_o_din     (ram_o_din),
        .ram_o_we      (ram_o_we),
        .des_in        (des_in),
        .des_round_sel (des_round_sel),
        .des_key       (des_key),
        .des_decrypt   (des_decrypt),
        .des_out       (des_out),
        .led           (led)
    );

    // Input RAM with one-cycle read latency.
    always @(posedge clk1) ram_i_dout <= in_mem[ram_i_addr];

    // Toy round core: only the round-15 output is meaningful, so a sequencer
    // that latches on the wrong round picks up garbage.
    function automatic logic [63:0] toy_core(input logic [63:0] x, input logic dec,
                                             input logic [55:0] k);
        return dec ? (x ^ {k, 8'h00}) : ~x;
    endfunction

    assign des_out = (des_round_sel == 4'd15) ? toy_core(des_in, des_decrypt, des_key)
                                              : 64'hBAD0_BAD0_BAD0_BAD0;

    // Reference key strip: keep the upper seven bits of every key byte.
    function automatic logic [55:0] ref_strip(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) r[b*7 +: 7] = k[b*8+1 +: 7];
        return r;
    endfunction

    function automatic logic [63:0] ref_block(input int n);
        return toy_core({in_mem[2*n+1], in_mem[2*n]}, decrypt, ref_strip(key));
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic fill_random(input bit fixed_first);
        for (int i = 0; i < 512; i++) in_mem[i] = $urandom;
        if (fixed_first) begin
            in_mem[0] = 32'h89ABCDEF;
            in_mem[1] = 32'h01234567;
        end
    endtask

    // Starts a run (start high for the cycle following the current negedge)
    // and observes it cycle by cycle at the negedges. Cycle 1 is LOAD1 of
    // block 0. Optionally re-pulses start at cycle restart_c and asserts reset
    // at cycle reset_c; with a reset the run is followed for 10 more cycles.
    task automatic do_run(input int restart_c, input int reset_c);
        int wr_cnt;
        int done_cnt;
        int last;
        int n;
        int ph;
        int k;
        int exp_c;
        logic [63:0] blk;
        logic [7:0]  exp_led;

        wr_cnt   = 0;
        done_cnt = 0;
        last     = (reset_c > 0) ? reset_c + 10 : C_DONE_CYC + 1;

        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;

        for (int c = 1; c <= last; c++) begin
            start = (c == restart_c);
            reset = (c == reset_c);

            if (reset_c > 0 && c > reset_c) begin
                check("post_reset_we",    ram_o_we,   1'b0);
                check("post_reset_done",  done,       1'b0);
                check("post_reset_led",   led,        8'hFF);
                check("post_reset_oaddr", ram_o_addr, 9'd0);
                check("post_reset_iaddr", ram_i_addr, 9'd0);
                check("post_reset_desin", des_in,     64'd0);
            end else begin
                n  = (c - 1) / C_BLOCK_CYC;
                ph = (c - 1) % C_BLOCK_CYC;
                if (n < C_BLOCKS && ph >= 3 && ph <= 18) begin
                    exp_led = ~{4'h0, 4'(ph - 3)};
                    check("round_sel", des_round_sel, 64'(ph - 3));
                    check("led", led, exp_led);
                    if (ph == 3) check("des_in_entry", des_in, {in_mem[2*n+1], in_mem[2*n]});
                end
                if (ram_o_we) begin
                    k = wr_cnt;
                    if (k >= 2 * C_BLOCKS) begin
                        check("extra_write", 1'b1, 1'b0);
                    end else begin
                        blk   = ref_block(k / 2);
                        exp_c = C_BLOCK_CYC * (k / 2) + 21 + (k % 2);
                        check("write_cycle", 64'(c), 64'(exp_c));
                        check("write_addr", ram_o_addr, 64'(k));
                        check("write_data", ram_o_din, (k % 2) ? blk[63:32] : blk[31:0]);
                    end
                    out_mem[ram_o_addr] = ram_o_din;
                    wr_cnt++;
                end
                if (done) begin
                    done_cnt++;
                    check("done_cycle", 64'(c), 64'(C_DONE_CYC));
                end
            end

            if (c != last) @(negedge clk1);
        end
        start = 1'b0;
        reset = 1'b0;

        if (reset_c > 0) begin
            n = (reset_c - 1) / C_BLOCK_CYC;
            check("abort_write_count", 64'(wr_cnt), 64'(2 * n));
            check("abort_done_count",  64'(done_cnt), 64'd0);
        end else begin
            check("write_count", 64'(wr_cnt), 64'(2 * C_BLOCKS));
            check("done_count",  64'(done_cnt), 64'd1);
        end
    endtask

    initial begin
        logic [63:0] rk;

        reset   = 1'b1;
        start   = 1'b0;
        decrypt = 1'b0;
        key     = 64'h0123456789ABCDEF;
        for (int i = 0; i < 512; i++) begin
            in_mem[i]  = 32'd0;
            out_mem[i] = 32'd0;
        end

        repeat (3) @(negedge clk1);
        check("rst_done",  done,          1'b0);
        check("rst_we",    ram_o_we,      1'b0);
        check("rst_iaddr", ram_i_addr,    9'd0);
        check("rst_oaddr", ram_o_addr,    9'd0);
        check("rst_din",   ram_o_din,     32'd0);
        check("rst_desin", des_in,        64'd0);
        check("rst_round", des_round_sel, 4'd0);
        check("rst_led",   led,           8'hFF);
        reset = 1'b0;
        @(negedge clk1);

        // Key strip, both modes, then random keys against the reference strip.
        check("key_strip_enc", des_key,
              {7'h00, 7'h11, 7'h22, 7'h33, 7'h44, 7'h55, 7'h66, 7'h77});
        check("decrypt_pass0", des_decrypt, 1'b0);
        decrypt = 1'b1;
        #1;
        check("key_strip_dec", des_key,
              {7'h00, 7'h11, 7'h22, 7'h33, 7'h44, 7'h55, 7'h66, 7'h77});
        check("decrypt_pass1", des_decrypt, 1'b1);
        for (int i = 0; i < 8; i++) begin
            rk  = {$urandom, $urandom};
            key = rk;
            #1;
            check("key_strip_rand", des_key, ref_strip(rk));
        end
        @(negedge clk1);

        // Run A: encrypt, known first block, plain full run.
        decrypt = 1'b0;
        key     = 64'h0123456789ABCDEF;
        fill_random(1'b1);
        do_run(0, 0);
        check("single_lo", out_mem[0], 32'h76543210);
        check("single_hi", out_mem[1], 32'hFEDCBA98);

        // Run B: same data, started one cycle after done, with a stray start
        // during block 3 DODES.
        do_run(C_BLOCK_CYC * 3 + 9, 0);

        // Run C: decrypt, random key; reset in block 10 SAVE1.
        decrypt = 1'b1;
        key     = {$urandom, $urandom};
        fill_random(1'b0);
        do_run(0, C_BLOCK_CYC * 10 + 20);

        // Run D: fresh start after the aborted run restarts from address 0.
        do_run(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
